regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//   Write-side driver for the 32x32 MIPS register file. Buffers register write-back results
//   from the execute/memory stages, including late producers such as the multi-cycle
//   multiply/divide unit. Issues them to the register file's regwrite/dst_adr/write_data
//   write port one per cycle, in arrival order.
//   Exposes two forwarding lookup ports so the operand-read path sees writes that are
//   still queued.
// PARAMETERS
//   DEPTH  4   queue entries; power of two, >= 2
//   DW     32  write data width
// PORTS
//   clk         in   1   rising-edge clock
//   reset_n     in   1   asynchronous active-low reset
//   in_valid    in   1   producer offers a write-back
//   in_ready    out  1   queue can accept; transfer when in_valid & in_ready at clk edge
//   in_dst      in   5   destination register address
//   in_data     in   DW  destination data
//   wb_hold     in   1   1 = do not issue this cycle (register file busy/stall)
//   regwrite    out  1   register file write enable; registered, one-cycle pulse per write
//   dst_adr     out  5   register file write address; registered
//   write_data  out  DW  register file write data; registered
//   q1_adr      in   5   lookup address, operand 1
//   q1_hit      out  1   q1_adr has a pending write
//   q1_data     out  DW  youngest pending data for q1_adr (0 when no hit)
//   q2_adr      in   5   lookup address, operand 2
//   q2_hit      out  1   same as q1, operand 2
//   q2_data     out  DW  same as q1, operand 2
//   count       out  $clog2(DEPTH)+1  queued entries, excluding the output stage
//   idle        out  1   count==0 & ~regwrite
// BEHAVIOUR
//   Reset (async, reset_n=0): queue emptied, pointers=0, count=0.
//     regwrite=0, dst_adr=0, write_data=0.
//     A reset mid-operation discards all queued entries. No partial write is issued.
//   Circular FIFO with wr_ptr, rd_ptr and count. in_ready = (count != DEPTH).
//     There is no same-cycle pass-through when full.
//   Push: on an edge with in_valid & in_ready, store {in_dst, in_data} at wr_ptr.
//     The pointer wraps from DEPTH-1 to 0.
//   Zero register: in_dst==0 is accepted, but the entry is never written.
//     Inserting it costs a queue slot, and it still pops in order.
//     It is popped with regwrite=0, and lookup never hits address 0.
//   Issue: on an edge with count!=0 & ~wb_hold, pop the head into dst_adr/write_data.
//     regwrite=1 for the next cycle, unless the head's dst is 0.
//     Otherwise regwrite=0 at that edge.
//     When regwrite is 0, dst_adr/write_data keep their last values.
//   Simultaneous push and pop: both take effect and count is unchanged.
//     This is legal only when count!=DEPTH before the edge, because in_ready gates the push.
//   Latency: an entry pushed at edge N into an empty queue, with wb_hold=0, is popped at edge N+1.
//     regwrite is high from edge N+1 to edge N+2. Peak throughput is 1 write per cycle.
//   wb_hold=1: nothing is popped. regwrite drops to 0 at the next edge. Pushes continue until full.
//   Lookup (combinational) for each qX_adr != 0:
//     Search the queued entries youngest-first, then the output stage if regwrite=1.
//     The first match gives qX_hit=1 and qX_data = that entry's data.
//     With no match, qX_hit=0 and qX_data=0.
//     The entry being pushed in the current cycle is not visible until after the edge.
//   Width: count is sized to hold DEPTH exactly. Pointers are $clog2(DEPTH) bits and wrap naturally.
// TESTING
//   1 Reset, then push {r8, 0xDEADBEEF} at edge 1, wb_hold=0.
//     -> regwrite=1, dst_adr=8, write_data=0xDEADBEEF during cycle 2 only; idle=1 after.
//   2 wb_hold=1, push r1..r4 (data 0x11..0x44).
//     -> in_ready=0 with count=4; a 5th offer is not accepted.
//     Release the hold -> 4 consecutive pulses r1..r4 in order, one per cycle.
//   3 Hold, push {r5, 0xA}, then {r5, 0xB}; q1_adr=5.
//     -> q1_hit=1, q1_data=0xB.
//     After both issue and regwrite falls -> q1_hit=0.
//   4 Push {r0, 0x1234}, then {r9, 0x5}.
//     -> no regwrite during the r0 pop cycle, then r9 is written.
//     q1_adr=0 -> q1_hit=0 throughout.
//   5 Full queue, pulse reset_n low mid-drain.
//     -> regwrite=0, dst_adr=0, count=0 immediately. No further writes after release.
//   6 Steady push every cycle with wb_hold=0.
//     -> count stays at 1 or less, with one write per cycle and no lost or reordered entries.
//     The scoreboard compares against a register-file model.

Source files
------------

// File: rtl/regfile_wb_queue_if.sv
// Write-back producer handshake bundle for regfile_wb_queue.
//   in_valid : producer offers a write-back
//   in_ready : queue can accept (transfer when in_valid & in_ready at clk edge)
//   in_dst   : destination register address
//   in_data  : destination data
interface regfile_wb_queue_if #(
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_dst;
  logic [DW-1:0] in_data;

  // Producer side
  modport master (output in_valid, output in_dst, output in_data, input in_ready);
  // Queue side
  modport slave  (input in_valid, input in_dst, input in_data, output in_ready);
endinterface

// File: rtl/regfile_wb_queue.sv
// Write-side driver for the 32x32 MIPS register file.
// Buffers write-back results in arrival order and issues them one per cycle
// to the register file write port. Two combinational forwarding lookups
// expose writes that are still queued or sitting in the output stage.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wb (slave modport)    producer handshake: in_valid/in_ready/in_dst/in_data
//   wb_hold               1 = do not issue this cycle
//   regwrite/dst_adr/write_data   registered register-file write port
//   q1_adr/q1_hit/q1_data, q2_adr/q2_hit/q2_data   forwarding lookups
//   count                 queued entries, excluding the output stage
//   idle                  count==0 & ~regwrite
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regfile_wb_queue_if.slave      wb,
  input  logic                   wb_hold,
  output logic                   regwrite,
  output logic [4:0]             dst_adr,
  output logic [DW-1:0]          write_data,
  input  logic [4:0]             q1_adr,
  output logic                   q1_hit,
  output logic [DW-1:0]          q1_data,
  input  logic [4:0]             q2_adr,
  output logic                   q2_hit,
  output logic [DW-1:0]          q2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]    dst;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  entry_t          head;
  logic            push;
  logic            pop;

  assign wb.in_ready = (count != CW'(DEPTH));
  assign push        = wb.in_valid & wb.in_ready;
  assign pop         = (count != '0) & ~wb_hold;
  assign head        = mem[rd_ptr];
  assign idle        = (count == '0) & ~regwrite;

  // Entry storage; validity is tracked by count, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dst: wb.in_dst, data: wb.in_data};
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: r0 entries are popped silently and leave the last address/data in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwrite   <= 1'b0;
      dst_adr    <= '0;
      write_data <= '0;
    end else begin
      regwrite <= 1'b0;
      if (pop && (head.dst != 5'd0)) begin
        regwrite   <= 1'b1;
        dst_adr    <= head.dst;
        write_data <= head.data;
      end
    end
  end

  // Forwarding search: output stage has lowest priority, then queue oldest to
  // youngest so the youngest match overwrites earlier ones
  function automatic logic [DW:0] lookup(input logic [4:0] adr);
    logic          hit;
    logic [DW-1:0] dat;
    logic [AW-1:0] idx;
    hit = 1'b0;
    dat = '0;
    idx = '0;
    if (adr != 5'd0) begin
      if (regwrite && (dst_adr == adr)) begin
        hit = 1'b1;
        dat = write_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + AW'(i);
        if ((CW'(i) < count) && (mem[idx].dst == adr)) begin
          hit = 1'b1;
          dat = mem[idx].data;
        end
      end
    end
    return {hit, dat};
  endfunction

  // Operand lookups
  always_comb begin
    {q1_hit, q1_data} = lookup(q1_adr);
    {q2_hit, q2_data} = lookup(q2_adr);
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue.
module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic          clk;
  logic          reset_n;
  logic          wb_hold;
  logic          regwrite;
  logic [4:0]    dst_adr;
  logic [DW-1:0] write_data;
  logic [4:0]    q1_adr;
  logic          q1_hit;
  logic [DW-1:0] q1_data;
  logic [4:0]    q2_adr;
  logic          q2_hit;
  logic [DW-1:0] q2_data;
  logic [2:0]    count;
  logic          idle;

  regfile_wb_queue_if #(.DW(DW)) wb_if ();

  regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wb         (wb_if.slave),
    .wb_hold    (wb_hold),
    .regwrite   (regwrite),
    .dst_adr    (dst_adr),
    .write_data (write_data),
    .q1_adr     (q1_adr),
    .q1_hit     (q1_hit),
    .q1_data    (q1_data),
    .q2_adr     (q2_adr),
    .q2_hit     (q2_hit),
    .q2_data    (q2_data),
    .count      (count),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [36:0] sbq [$];
  logic [31:0] rf_model [32];
  logic [31:0] rf_dut   [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] d, input logic [31:0] v);
    wb_if.in_valid = 1'b1;
    wb_if.in_dst   = d;
    wb_if.in_data  = v;
    tick();
    wb_if.in_valid = 1'b0;
  endtask

  initial begin
    logic [36:0] e;
    logic [4:0]  d;
    logic [31:0] v;
    int          nwr;

    reset_n        = 1'b0;
    wb_hold        = 1'b0;
    q1_adr         = 5'd0;
    q2_adr         = 5'd0;
    wb_if.in_valid = 1'b0;
    wb_if.in_dst   = 5'd0;
    wb_if.in_data  = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_dst_adr", 32'(dst_adr), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(wb_if.in_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    reset_n = 1'b1;
    tick();

    // 1: single write, one-cycle pulse
    offer(5'd8, 32'hDEADBEEF);
    chk("t1_count_after_push", 32'(count), 32'd1);
    chk("t1_no_write_yet", 32'(regwrite), 32'd0);
    tick();
    chk("t1_regwrite", 32'(regwrite), 32'd1);
    chk("t1_dst_adr", 32'(dst_adr), 32'd8);
    chk("t1_write_data", write_data, 32'hDEADBEEF);
    chk("t1_count_drained", 32'(count), 32'd0);
    tick();
    chk("t1_regwrite_off", 32'(regwrite), 32'd0);
    chk("t1_idle", 32'(idle), 32'd1);

    // 2: fill under hold, reject 5th, drain in order
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) offer(5'(i), 32'(i * 32'h11));
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_in_ready_full", 32'(wb_if.in_ready), 32'd0);
    chk("t2_no_write_held", 32'(regwrite), 32'd0);
    offer(5'd5, 32'h55);
    chk("t2_count_after_5th", 32'(count), 32'd4);
    wb_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_drain_regwrite", 32'(regwrite), 32'd1);
      chk("t2_drain_dst", 32'(dst_adr), 32'(i));
      chk("t2_drain_data", write_data, 32'(i * 32'h11));
      chk("t2_drain_count", 32'(count), 32'(4 - i));
    end
    tick();
    chk("t2_regwrite_off", 32'(regwrite), 32'd0);
    chk("t2_idle", 32'(idle), 32'd1);

    // 3: youngest-first forwarding
    wb_hold = 1'b1;
    offer(5'd5, 32'hA);
    offer(5'd5, 32'hB);
    q1_adr = 5'd5;
    q2_adr = 5'd5;
    #1;
    chk("t3_q1_hit", 32'(q1_hit), 32'd1);
    chk("t3_q1_data", q1_data, 32'hB);
    chk("t3_q2_hit", 32'(q2_hit), 32'd1);
    chk("t3_q2_data", q2_data, 32'hB);
    wb_hold = 1'b0;
    tick();
    chk("t3_first_pop_data", write_data, 32'hA);
    chk("t3_q1_data_queued", q1_data, 32'hB);
    tick();
    chk("t3_second_pop_data", write_data, 32'hB);
    chk("t3_q1_hit_outstage", 32'(q1_hit), 32'd1);
    chk("t3_q1_data_outstage", q1_data, 32'hB);
    tick();
    chk("t3_q1_hit_gone", 32'(q1_hit), 32'd0);
    chk("t3_q1_data_gone", q1_data, 32'd0);
    q2_adr = 5'd0;

    // 4: r0 entry pops silently
    wb_hold = 1'b1;
    q1_adr  = 5'd0;
    offer(5'd0, 32'h1234);
    offer(5'd9, 32'h5);
    chk("t4_count", 32'(count), 32'd2);
    chk("t4_q1_hit_r0_queued", 32'(q1_hit), 32'd0);
    chk("t4_q1_data_r0", q1_data, 32'd0);
    wb_hold = 1'b0;
    tick();
    chk("t4_r0_no_regwrite", 32'(regwrite), 32'd0);
    chk("t4_r0_dst_kept", 32'(dst_adr), 32'd5);
    chk("t4_r0_data_kept", write_data, 32'hB);
    chk("t4_q1_hit_r0_pop", 32'(q1_hit), 32'd0);
    tick();
    chk("t4_r9_regwrite", 32'(regwrite), 32'd1);
    chk("t4_r9_dst", 32'(dst_adr), 32'd9);
    chk("t4_r9_data", write_data, 32'h5);
    q1_adr = 5'd9;
    #1;
    chk("t4_q1_hit_r9_outstage", 32'(q1_hit), 32'd1);
    q1_adr = 5'd0;
    tick();
    chk("t4_regwrite_off", 32'(regwrite), 32'd0);

    // 5: reset mid-drain
    wb_hold = 1'b1;
    for (int i = 10; i <= 13; i++) offer(5'(i), 32'(i));
    wb_hold = 1'b0;
    tick();
    chk("t5_drain_started", 32'(regwrite), 32'd1);
    chk("t5_drain_count", 32'(count), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_regwrite", 32'(regwrite), 32'd0);
    chk("t5_rst_dst_adr", 32'(dst_adr), 32'd0);
    chk("t5_rst_write_data", write_data, 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_write_after", 32'(regwrite), 32'd0);
      chk("t5_count_after", 32'(count), 32'd0);
    end

    // 6: streaming against a register-file model
    for (int r = 0; r < 32; r++) begin
      rf_model[r] = 32'd0;
      rf_dut[r]   = 32'd0;
    end
    nwr = 0;
    for (int i = 0; i < 28; i++) begin
      if (i < 24) begin
        d = 5'((i * 7) % 32);
        v = 32'h1000_0000 + 32'(i * 32'h0101);
        wb_if.in_valid = 1'b1;
        wb_if.in_dst   = d;
        wb_if.in_data  = v;
        if (d != 5'd0) begin
          sbq.push_back({d, v});
          rf_model[d] = v;
        end
      end else begin
        wb_if.in_valid = 1'b0;
      end
      tick();
      tests++;
      assert (count <= 3'd1) else begin
        fails++;
        $error("FAIL t6_count_bound observed=%0d expected<=1", count);
      end
      if (regwrite) begin
        nwr++;
        if (sbq.size() == 0) begin
          chk("t6_spurious_write", 32'(dst_adr), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("t6_dst_order", 32'(dst_adr), 32'(e[36:32]));
          chk("t6_data_order", write_data, e[31:0]);
          rf_dut[dst_adr] = write_data;
        end
      end
    end
    chk("t6_write_total", 32'(nwr), 32'd23);
    chk("t6_queue_empty", 32'(sbq.size()), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    for (int r = 0; r < 32; r++) chk("t6_regfile", rf_dut[r], rf_model[r]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
